// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one downstream memory port between the fetch unit (F)
// and the dcache (D). Round-robin selection with the grant locked while the
// downstream stalls, in-order response routing through a source-tag FIFO, and
// squash-driven dropping of in-flight fetch responses.
module mem_port_arbiter #(
    parameter int XLEN      = 64,
    parameter int DATA_W    = 64,
    parameter int MAX_OUTST = 4
) (
    input  logic                clk,
    input  logic                rst,
    // fetch requester
    input  logic                f_req_valid,
    output logic                f_req_ready,
    input  logic [XLEN-1:0]     f_req_addr,
    output logic                f_rsp_valid,
    input  logic                f_rsp_ready,
    output logic [DATA_W-1:0]   f_rsp_data,
    // dcache requester
    input  logic                d_req_valid,
    output logic                d_req_ready,
    input  logic [XLEN-1:0]     d_req_addr,
    input  logic                d_req_we,
    input  logic [DATA_W-1:0]   d_req_wdata,
    input  logic [DATA_W/8-1:0] d_req_wstrb,
    output logic                d_rsp_valid,
    input  logic                d_rsp_ready,
    output logic [DATA_W-1:0]   d_rsp_data,
    // downstream memory port
    output logic                m_req_valid,
    input  logic                m_req_ready,
    output logic [XLEN-1:0]     m_req_addr,
    output logic                m_req_we,
    output logic [DATA_W-1:0]   m_req_wdata,
    output logic [DATA_W/8-1:0] m_req_wstrb,
    input  logic                m_rsp_valid,
    output logic                m_rsp_ready,
    input  logic [DATA_W-1:0]   m_rsp_data,
    // control / status
    input  logic                squash_i,
    output logic                busy_o
);

    localparam int PW = $clog2(MAX_OUTST);
    localparam int CW = PW + 1;

    typedef enum logic {ARB, HOLD} state_t;
    typedef enum logic {SRC_F = 1'b0, SRC_D = 1'b1} src_t;

    state_t state, state_nxt;
    src_t   lock_src, lock_src_nxt;
    src_t   rr_last, rr_last_nxt;
    src_t   sel_src;
    logic   sel_valid;
    logic   accept;

    // Tag FIFO: one entry per outstanding downstream request.
    logic [MAX_OUTST-1:0] q_is_f;
    logic [MAX_OUTST-1:0] q_disc;
    logic [PW-1:0]        rd_ptr, wr_ptr;
    logic [CW-1:0]        count;
    logic                 fifo_full, fifo_empty;
    logic                 head_is_f, head_disc;
    logic                 push, pop;

    assign fifo_full  = (count == CW'(MAX_OUTST));
    assign fifo_empty = (count == '0);
    assign busy_o     = !fifo_empty;
    assign head_is_f  = q_is_f[rd_ptr];
    // A squash in this very cycle turns a fetch head into a silent drop.
    assign head_disc  = q_disc[rd_ptr] || (squash_i && head_is_f);
    assign push       = accept;
    assign pop        = m_rsp_valid && m_rsp_ready;

    // Arbitration state register: FSM state, locked source, round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ARB;
            lock_src <= SRC_F;
            rr_last  <= SRC_D;
        end else begin
            // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
            state    <= state_nxt;
            lock_src <= lock_src_nxt;
            rr_last  <= rr_last_nxt;
        end
    end

    // Next-state: lock on a stalled offer, release and advance round-robin on accept.
    always_comb begin
        // NOTE: defaults first so no path leaves a combinational output unassigned (no latch).
        state_nxt    = state;
        lock_src_nxt = lock_src;
        rr_last_nxt  = rr_last;
        if (accept) begin
            state_nxt   = ARB;
            rr_last_nxt = sel_src;
        end else if (m_req_valid) begin
            state_nxt    = HOLD;
            lock_src_nxt = sel_src;
        end
    end

    // Outputs: source selection, request mux, handshakes and response routing.
    always_comb begin
        if (state == HOLD) begin
            sel_src = lock_src;
        end else if (f_req_valid && d_req_valid) begin
            sel_src = (rr_last == SRC_F) ? SRC_D : SRC_F;
        end else if (f_req_valid) begin
            sel_src = SRC_F;
        end else begin
            sel_src = SRC_D;
        end
        sel_valid   = (sel_src == SRC_F) ? f_req_valid : d_req_valid;
        m_req_valid = sel_valid && !fifo_full;
        accept      = m_req_valid && m_req_ready;
        f_req_ready = accept && (sel_src == SRC_F);
        d_req_ready = accept && (sel_src == SRC_D);

        if (sel_src == SRC_F) begin
            m_req_addr  = f_req_addr;
            m_req_we    = 1'b0;
            m_req_wdata = '0;
            m_req_wstrb = '0;
        end else begin
            m_req_addr  = d_req_addr;
            m_req_we    = d_req_we;
            m_req_wdata = d_req_wdata;
            m_req_wstrb = d_req_wstrb;
        end

        f_rsp_valid = 1'b0;
        d_rsp_valid = 1'b0;
        m_rsp_ready = 1'b0;
        f_rsp_data  = m_rsp_data;
        d_rsp_data  = m_rsp_data;
        if (!fifo_empty) begin
            if (head_disc) begin
                m_rsp_ready = 1'b1;
            end else if (head_is_f) begin
                f_rsp_valid = m_rsp_valid;
                m_rsp_ready = f_rsp_ready;
            end else begin
                d_rsp_valid = m_rsp_valid;
                m_rsp_ready = d_rsp_ready;
            end
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // FIFO storage: squash marks every fetch entry, including one written this cycle.
    always_ff @(posedge clk) begin
        // NOTE: tag storage has no reset; count gates every read, so stale entries are never observed.
        for (int i = 0; i < MAX_OUTST; i++) begin
            if (squash_i && q_is_f[i]) q_disc[i] <= 1'b1;
        end
        if (push) begin
            q_is_f[wr_ptr] <= (sel_src == SRC_F);
            q_disc[wr_ptr] <= squash_i && (sel_src == SRC_F);
        end
    end

    // A downstream response with nothing outstanding is a protocol violation.
    assert property (@(posedge clk) disable iff (rst) !(m_rsp_valid && fifo_empty));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a queue-based reference model.
module tb_mem_port_arbiter;

    localparam int XLEN   = 64;
    localparam int DATA_W = 64;
    localparam int SW     = DATA_W / 8;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              f_req_valid, f_req_ready;
    logic [XLEN-1:0]   f_req_addr;
    logic              f_rsp_valid, f_rsp_ready;
    logic [DATA_W-1:0] f_rsp_data;
    logic              d_req_valid, d_req_ready;
    logic [XLEN-1:0]   d_req_addr;
    logic              d_req_we;
    logic [DATA_W-1:0] d_req_wdata;
    logic [SW-1:0]     d_req_wstrb;
    logic              d_rsp_valid, d_rsp_ready;
    logic [DATA_W-1:0] d_rsp_data;
    logic              m_req_valid, m_req_ready;
    logic [XLEN-1:0]   m_req_addr;
    logic              m_req_we;
    logic [DATA_W-1:0] m_req_wdata;
    logic [SW-1:0]     m_req_wstrb;
    logic              m_rsp_valid, m_rsp_ready;
    logic [DATA_W-1:0] m_rsp_data;
    logic              squash_i;
    logic              busy_o;

    mem_port_arbiter #(.XLEN(XLEN), .DATA_W(DATA_W), .MAX_OUTST(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .f_req_valid(f_req_valid), .f_req_ready(f_req_ready), .f_req_addr(f_req_addr),
        .f_rsp_valid(f_rsp_valid), .f_rsp_ready(f_rsp_ready), .f_rsp_data(f_rsp_data),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
        .d_req_we(d_req_we), .d_req_wdata(d_req_wdata), .d_req_wstrb(d_req_wstrb),
        .d_rsp_valid(d_rsp_valid), .d_rsp_ready(d_rsp_ready), .d_rsp_data(d_rsp_data),
        .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_addr(m_req_addr),
        .m_req_we(m_req_we), .m_req_wdata(m_req_wdata), .m_req_wstrb(m_req_wstrb),
        .m_rsp_valid(m_rsp_valid), .m_rsp_ready(m_rsp_ready), .m_rsp_data(m_rsp_data),
        .squash_i(squash_i), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    // Reference model: outstanding requests in issue order, plus the downstream's own queue.
    typedef struct {
        bit          is_f;
        bit          disc;
        logic [63:0] data;
    } tag_t;

    tag_t        tagq[$];
    logic [63:0] memq[$];
    bit          last_was_d;   // round-robin: who won the most recent accept
    bit          locked;
    bit          lock_is_f;
    bit          f_done, d_done;
    bit          force_both;

    int n_vec = 0;
    int n_err = 0;
    int p_f, p_d, p_mready, p_rsp, p_sq;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    // Downstream memory returns a value derived from the request it saw.
    function automatic logic [63:0] rsp_of(input logic [63:0] addr, input logic we,
                                           input logic [63:0] wdata);
        return we ? (64'hACCE_55ED_0000_0000 ^ wdata) : (addr * 3 + 64'h1234);
    endfunction

    function automatic bit coin(input int pct);
        return $urandom_range(99) < pct;
    endfunction

    task automatic model_reset();
        tagq.delete();
        memq.delete();
        last_was_d = 1'b1;
        locked     = 1'b0;
        lock_is_f  = 1'b0;
        f_done     = 1'b0;
        d_done     = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        f_req_valid = 1'b0; d_req_valid = 1'b0;
        m_req_ready = 1'b0; m_rsp_valid = 1'b0; squash_i = 1'b0;
        f_rsp_ready = 1'b0; d_rsp_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        check("rst_busy",        busy_o,      1'b0);
        check("rst_m_req_valid", m_req_valid, 1'b0);
        check("rst_m_rsp_ready", m_rsp_ready, 1'b0);
        check("rst_f_rsp_valid", f_rsp_valid, 1'b0);
        check("rst_d_rsp_valid", d_rsp_valid, 1'b0);
        force_both = 1'b1;   // first cycle after reset: tie must go to F
    endtask

    task automatic cycle();
        bit sel_f, sel_v, exp_mv, acc, disc, exp_mr, exp_fv, exp_dv, pop;
        tag_t h;
        @(posedge clk); #1;
        // Requesters hold their request until accepted.
        if (f_done) begin f_req_valid = 1'b0; f_done = 1'b0; end
        if (d_done) begin d_req_valid = 1'b0; d_done = 1'b0; end
        if (!f_req_valid && (force_both || coin(p_f))) begin
            f_req_valid = 1'b1;
            f_req_addr  = {$urandom, $urandom};
        end
        if (!d_req_valid && (force_both || coin(p_d))) begin
            d_req_valid = 1'b1;
            d_req_addr  = {$urandom, $urandom};
            d_req_we    = coin(50);
            d_req_wdata = {$urandom, $urandom};
            d_req_wstrb = SW'($urandom);
        end
        m_req_ready = force_both ? 1'b1 : coin(p_mready);
        force_both  = 1'b0;
        f_rsp_ready = coin(70);
        d_rsp_ready = coin(70);
        squash_i    = coin(p_sq);
        if (memq.size() > 0 && coin(p_rsp)) begin
            m_rsp_valid = 1'b1;
            m_rsp_data  = memq[0];
        end else begin
            m_rsp_valid = 1'b0;
            m_rsp_data  = {$urandom, $urandom};
        end

        @(negedge clk);
        // Request side.
        if (locked)                          sel_f = lock_is_f;
        else if (f_req_valid && d_req_valid) sel_f = last_was_d;
        else                                 sel_f = f_req_valid;
        sel_v  = sel_f ? f_req_valid : d_req_valid;
        exp_mv = sel_v && (tagq.size() < DEPTH);
        acc    = exp_mv && m_req_ready;
        check("m_req_valid", m_req_valid, exp_mv);
        if (exp_mv) begin
            check("m_req_addr",  m_req_addr,  sel_f ? f_req_addr : d_req_addr);
            check("m_req_we",    m_req_we,    sel_f ? 1'b0 : d_req_we);
            check("m_req_wdata", m_req_wdata, sel_f ? '0 : d_req_wdata);
            check("m_req_wstrb", m_req_wstrb, sel_f ? '0 : d_req_wstrb);
        end
        check("f_req_ready", f_req_ready, acc && sel_f);
        check("d_req_ready", d_req_ready, acc && !sel_f);
        check("busy_o", busy_o, tagq.size() != 0);

        // Response side.
        exp_mr = 1'b0; exp_fv = 1'b0; exp_dv = 1'b0;
        if (tagq.size() > 0) begin
            h    = tagq[0];
            disc = h.disc || (squash_i && h.is_f);
            exp_mr = disc ? 1'b1 : (h.is_f ? f_rsp_ready : d_rsp_ready);
            exp_fv = m_rsp_valid && !disc && h.is_f;
            exp_dv = m_rsp_valid && !disc && !h.is_f;
            if (exp_fv) check("f_rsp_data", f_rsp_data, h.data);
            if (exp_dv) check("d_rsp_data", d_rsp_data, h.data);
        end
        check("m_rsp_ready", m_rsp_ready, exp_mr);
        check("f_rsp_valid", f_rsp_valid, exp_fv);
        check("d_rsp_valid", d_rsp_valid, exp_dv);

        // Model update for the coming edge.
        pop = m_rsp_valid && exp_mr;
        if (pop) begin
            void'(tagq.pop_front());
            void'(memq.pop_front());
        end
        if (squash_i) begin
            foreach (tagq[i]) if (tagq[i].is_f) tagq[i].disc = 1'b1;
        end
        if (acc) begin
            h.is_f = sel_f;
            h.disc = squash_i && sel_f;
            h.data = sel_f ? rsp_of(f_req_addr, 1'b0, '0)
                           : rsp_of(d_req_addr, d_req_we, d_req_wdata);
            tagq.push_back(h);
            memq.push_back(rsp_of(m_req_addr, m_req_we, m_req_wdata));
            last_was_d = !sel_f;
            locked     = 1'b0;
            if (sel_f) f_done = 1'b1; else d_done = 1'b1;
        end else if (exp_mv) begin
            locked    = 1'b1;
            lock_is_f = sel_f;
        end
    endtask

    task automatic run_phase(input int n, input int pf, input int pd, input int pm,
                             input int pr, input int ps);
        p_f = pf; p_d = pd; p_mready = pm; p_rsp = pr; p_sq = ps;
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        rst = 1'b1;
        f_req_valid = 1'b0; f_req_addr = '0;
        d_req_valid = 1'b0; d_req_addr = '0; d_req_we = 1'b0;
        d_req_wdata = '0; d_req_wstrb = '0;
        f_rsp_ready = 1'b0; d_rsp_ready = 1'b0;
        m_req_ready = 1'b0; m_rsp_valid = 1'b0; m_rsp_data = '0;
        squash_i = 1'b0;
        force_both = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);

        do_reset();
        run_phase(300, 60, 60, 80, 60, 5);    // mixed traffic
        run_phase(300, 90, 90, 100, 5, 3);    // fills the tag FIFO
        do_reset();                           // reset with requests outstanding
        run_phase(300, 70, 70, 30, 50, 5);    // frequent downstream stalls
        run_phase(300, 80, 40, 80, 70, 20);   // squash-heavy, fetch-dominated
        run_phase(200, 100, 100, 100, 50, 0); // both requesting every cycle
        do_reset();
        run_phase(200, 50, 50, 60, 40, 10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
